// File: rtl/serial_alu_sequencer.sv
// ---------------------------------------------------------------------------
// serial_alu_sequencer
//
// Runs a WIDTH-bit ALU operation through an external 1-bit ALU slice. The
// slice handles one bit per clock, starting at the LSB. This block latches
// the operands, presents one operand bit per cycle to the slice, and chains
// the slice carry from bit to bit. It assembles the result, then reports the
// Zero and signed Overflow flags.
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   start           operation request, sampled only while idle
//   A, B            WIDTH-bit operands
//   ALUOp           0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
//   slice_a/b       current operand bits driven to the slice
//   slice_CarryIn   carry into the slice (ALUOp[2] at bit 0, then chained)
//   slice_ALUOp     latched opcode driven to the slice
//   slice_Result    slice result bit (combinational in the slice)
//   slice_CarryOut  slice carry out (combinational in the slice)
//   busy            high while an operation is running or completing
//   done            one-cycle pulse, Result/Zero/Overflow valid
//   Result          assembled result, held until the next accepted start
//   Zero            Result == 0, held with Result
//   Overflow        signed overflow for ADD/SUB, 0 for every other opcode
// ---------------------------------------------------------------------------
module serial_alu_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_CarryIn,
    output logic [3:0]       slice_ALUOp,
    input  logic             slice_Result,
    input  logic             slice_CarryOut,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow
);

    localparam int              IW       = $clog2(WIDTH);
    localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);
    localparam logic [3:0]      OP_ADD   = 4'b0010;
    localparam logic [3:0]      OP_SUB   = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [WIDTH-1:0]  a_lat;
    logic [WIDTH-1:0]  b_lat;
    logic [3:0]        op_lat;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [WIDTH-1:0]  result_nx;
    logic              is_arith;
    logic              last_bit;

    assign slice_ALUOp = op_lat;
    assign is_arith    = (op_lat == OP_ADD) || (op_lat == OP_SUB);
    assign last_bit    = (idx == LAST_IDX);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and slice-facing outputs
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default before the case statement, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx      = state;
        busy          = 1'b0;
        done          = 1'b0;
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_CarryIn = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                slice_a = a_lat[idx];
                slice_b = b_lat[idx];
                // Bit 0 takes the subtract carry-in (ALUOp[2]); later bits
                // take the chained carry.
                slice_CarryIn = (idx == '0) ? op_lat[2] : carry;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The result with the current slice bit merged in. On the last bit this
    // is the final value, which lets Zero be computed on the same edge.
    always_comb begin
        result_nx      = Result;
        result_nx[idx] = slice_Result;
    end

    // -----------------------------------------------------------------------
    // Operand latches, bit index, carry chain and result assembly
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_lat    <= '0;
            b_lat    <= '0;
            op_lat   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat    <= A;
                        b_lat    <= B;
                        op_lat   <= ALUOp;
                        idx      <= '0;
                        carry    <= 1'b0;
                        Result   <= '0;
                        Zero     <= 1'b0;
                        Overflow <= 1'b0;
                    end
                end
                RUN: begin
                    Result <= result_nx;
                    carry  <= slice_CarryOut;
                    idx    <= idx + 1'b1;
                    if (last_bit) begin
                        // Signed overflow is the carry into the MSB XOR the
                        // carry out of it.
                        Overflow <= is_arith & (slice_CarryIn ^ slice_CarryOut);
                        Zero     <= (result_nx == '0);
                    end
                end
                default: begin
                    // DONE: hold everything; results stay valid.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serial_alu_sequencer
//
// Bench for serial_alu_sequencer with WIDTH=8. A 1-bit ALU slice is modelled
// combinationally. Expected results come from a word-level reference
// function that uses plain arithmetic. Operations from a fixed vector table
// run first. Hand-written sequences then cover busy, reset and back-to-back
// operation, followed by random operations.
// ---------------------------------------------------------------------------
module tb_serial_alu_sequencer;

    localparam int W = 8;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_UNL = 4'b0101;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALUOp;
    logic         slice_a;
    logic         slice_b;
    logic         slice_CarryIn;
    logic [3:0]   slice_ALUOp;
    logic         slice_Result;
    logic         slice_CarryOut;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .A              (A),
        .B              (B),
        .ALUOp          (ALUOp),
        .slice_a        (slice_a),
        .slice_b        (slice_b),
        .slice_CarryIn  (slice_CarryIn),
        .slice_ALUOp    (slice_ALUOp),
        .slice_Result   (slice_Result),
        .slice_CarryOut (slice_CarryOut),
        .busy           (busy),
        .done           (done),
        .Result         (Result),
        .Zero           (Zero),
        .Overflow       (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 1-bit ALU slice: B is inverted when ALUOp[2] is set (subtract), and
    // unlisted opcodes produce 0.
    logic slice_bx;
    assign slice_bx = slice_b ^ slice_ALUOp[2];

    always_comb begin
        slice_CarryOut = (slice_a & slice_bx) | (slice_a & slice_CarryIn) |
                         (slice_bx & slice_CarryIn);
        case (slice_ALUOp)
            OP_AND:         slice_Result = slice_a & slice_b;
            OP_OR:          slice_Result = slice_a | slice_b;
            OP_ADD, OP_SUB: slice_Result = slice_a ^ slice_bx ^ slice_CarryIn;
            OP_NOR:         slice_Result = ~(slice_a | slice_b);
            default:        slice_Result = 1'b0;
        endcase
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         o;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word-level reference. The overflow rule is the sign rule for
    // two's-complement add/sub.
    function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] res,
                                      output logic z, output logic o);
        o = 1'b0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_NOR: res = ~(a | b);
            OP_ADD: begin
                res = a + b;
                o   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                res = a - b;
                o   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            default: res = '0;
        endcase
        z = (res == '0);
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "/idle_before_start"}, 64'(busy), 64'(0));
    endtask

    // Issues one operation and checks its result, flags, latency and hold
    // behaviour. After acceptance the inputs are scrambled, so a result that
    // depends on live inputs is caught.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_z,
                          input logic exp_o);
        int           acc;
        int           dcyc;
        int           n;
        logic         d;
        logic [W-1:0] r;
        logic         zz;
        logic         oo;

        wait_idle(tag);
        A     = a;
        B     = b;
        ALUOp = op;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc   = cyc;
        check({tag, "/clear_result"}, 64'(Result), 64'(0));
        check({tag, "/clear_flags"}, 64'({Zero, Overflow}), 64'(0));
        check({tag, "/busy"}, 64'(busy), 64'(1));
        check({tag, "/bit0_cin"}, 64'(slice_CarryIn), 64'(op[2]));
        check({tag, "/bit0_ab"}, 64'({slice_a, slice_b}), 64'({a[0], b[0]}));
        check({tag, "/slice_op"}, 64'(slice_ALUOp), 64'(op));
        A     = ~a;
        B     = W'($urandom);
        ALUOp = ~op;

        n    = 0;
        d    = 1'b0;
        dcyc = 0;
        r    = '0;
        zz   = 1'b0;
        oo   = 1'b0;
        while (!d && n < 100) begin
            @(negedge clk);
            d    = done;
            r    = Result;
            zz   = Zero;
            oo   = Overflow;
            dcyc = cyc;
            n++;
        end
        // done seen in the cycle after edge dcyc is captured by edge dcyc+1.
        check({tag, "/latency"}, 64'(dcyc + 1 - acc), 64'(W + 1));
        check({tag, "/result"}, 64'(r), 64'(exp_res));
        check({tag, "/zero"}, 64'(zz), 64'(exp_z));
        check({tag, "/overflow"}, 64'(oo), 64'(exp_o));

        @(posedge clk);
        #1;
        check({tag, "/done_one_cycle"}, 64'({done, busy}), 64'(0));
        check({tag, "/idle_slice"}, 64'({slice_a, slice_b, slice_CarryIn}), 64'(0));
        check({tag, "/idle_slice_op"}, 64'(slice_ALUOp), 64'(op));
        repeat (2) @(posedge clk);
        #1;
        check({tag, "/hold"}, 64'({Result, Zero, Overflow}), 64'({exp_res, exp_z, exp_o}));
    endtask

    initial begin
        logic [W-1:0] exp_res;
        logic         exp_z;
        logic         exp_o;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic         o1;
        int           acc;
        int           d1;
        int           d2;
        int           ndone;
        int           idle_between;
        logic [3:0]   ops[5];

        vecs[0] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[3] = '{OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
        vecs[4] = '{OP_NOR, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{OP_UNL, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0};

        ops[0] = OP_AND;
        ops[1] = OP_OR;
        ops[2] = OP_ADD;
        ops[3] = OP_SUB;
        ops[4] = OP_NOR;

        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        ALUOp   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/outputs", 64'({busy, done, Zero, Overflow, slice_a, slice_b,
              slice_CarryIn}), 64'(0));
        check("reset/result", 64'(Result), 64'(0));
        check("reset/slice_op", 64'(slice_ALUOp), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].z, vecs[i].o);
        end

        // A second start with new operands mid-run is ignored, and no second
        // done follows.
        wait_idle("busy");
        A     = 8'h7F;
        B     = 8'h01;
        ALUOp = OP_ADD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc   = cyc;
        repeat (3) @(posedge clk);
        #1;
        A     = 8'h11;
        B     = 8'h22;
        ALUOp = OP_SUB;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        d1    = 0;
        r1    = '0;
        o1    = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = cyc;
                    r1 = Result;
                    o1 = Overflow;
                end
            end
        end
        check("busy/done_count", 64'(ndone), 64'(1));
        check("busy/latency", 64'(d1 + 1 - acc), 64'(W + 1));
        check("busy/result", 64'({r1, o1}), 64'({8'h80, 1'b1}));
        check("busy/no_queue", 64'(busy), 64'(0));

        // Reset at bit 4 of a subtraction drops everything immediately.
        @(posedge clk);
        #1;
        A     = 8'hFF;
        B     = 8'h00;
        ALUOp = OP_SUB;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid/pre_slice", 64'({slice_a, slice_b, slice_CarryIn}), 64'(3'b101));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid/flags", 64'({busy, done, Zero, Overflow}), 64'(0));
        check("rst_mid/slice", 64'({slice_a, slice_b, slice_CarryIn, slice_ALUOp}), 64'(0));
        check("rst_mid/result", 64'(Result), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("rst_then_add", OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // start held high: DONE, one IDLE cycle, then the next operation.
        wait_idle("b2b");
        A     = 8'h03;
        B     = 8'h04;
        ALUOp = OP_ADD;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc          = cyc;
        A            = 8'h10;
        B            = 8'h20;
        ndone        = 0;
        d1           = 0;
        d2           = 0;
        r1           = '0;
        r2           = '0;
        idle_between = 0;
        for (int k = 0; k < 40 && ndone < 2; k++) begin
            @(negedge clk);
            if (ndone == 1 && !busy) idle_between++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = cyc;
                    r1 = Result;
                end else begin
                    d2    = cyc;
                    r2    = Result;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b/done_count", 64'(ndone), 64'(2));
        check("b2b/first_latency", 64'(d1 + 1 - acc), 64'(W + 1));
        check("b2b/spacing", 64'(d2 - d1), 64'(W + 2));
        check("b2b/idle_cycles", 64'(idle_between), 64'(1));
        check("b2b/results", 64'({r1, r2}), 64'({8'h07, 8'h30}));

        for (int i = 0; i < 40; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = ops[$urandom_range(0, 4)];
            a  = W'($urandom);
            b  = W'($urandom);
            ref_model(op, a, b, exp_res, exp_z, exp_o);
            run_op($sformatf("rand%0d", i), op, a, b, exp_res, exp_z, exp_o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
